tdm_demux_1x8_4bit: RTL and testbench
=====================================

# tdm_demux_1x8_4bit

Receive-side counterpart of the 8-to-1 4-bit multiplexer: accepts a time-multiplexed stream of 4-bit words, one channel per valid beat, and distributes it back onto eight parallel 4-bit outputs a..h. The block owns the channel counter and drives sel2/sel1/sel0, so the same lines can steer an upstream 8x1 mux scan. Words are collected in a shadow bank, and all eight outputs update atomically once a full frame (channels 0..7) has arrived. A sync input realigns the frame.

## Interface
- No parameters; data width is fixed at 4 bits and the channel count at 8.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- in  input  4  multiplexed data word
- valid  input  1  in carries a word for the current channel this cycle
- sync  input  1  start-of-frame marker; qualifies the word on in as channel 0
- enable  input  1  block enable; low freezes all state
- sel0, sel1, sel2  output  1 each  current channel index {sel2,sel1,sel0}, registered
- a, b, c, d, e, f, g, h  output  4 each  demultiplexed channels 0..7, registered
- frame_done  output  1  one-cycle pulse: a..h were just updated with a complete frame
- frame_err  output  1  one-cycle pulse: sync cut a partial frame short

## Operation
- State:
  - 3-bit channel counter ch, driven out on {sel2,sel1,sel0}.
  - Shadow bank sh[0..7], 4 bits each.
  - Output bank a..h.
  - Pulse registers frame_done and frame_err.
- Reset (rst_n low at a rising edge) clears all of the above to 0. Reset overrides every other input, including a reset asserted mid-frame; the partial frame is lost.
- enable low: no state changes, valid and sync are ignored, and both pulses are 0.
- With enable high, exactly one of the following applies per cycle, in priority order.
- Case 1, sync=1 and valid=1:
  - in is written to sh[0].
  - ch becomes 1.
  - frame_err=1 if ch was not 0, else 0.
- Case 2, sync=1 and valid=0:
  - ch becomes 0.
  - frame_err=1 if ch was not 0.
  - No shadow write.
- Case 3, sync=0 and valid=1:
  - in is written to sh[ch].
  - ch increments modulo 8, so 7 wraps to 0.
  - If ch was 7, a complete frame has arrived:
    - a..h load sh[0]..sh[6] and in (h takes in directly, not the stale sh[7]).
    - frame_done=1.
- Case 4, sync=0 and valid=0: hold, with pulses 0.
- Frame completion requires 8 consecutive accepted words starting from ch=0. After a sync-aborted frame, a..h keep their previous complete-frame values; the aborted shadow entries are overwritten by the next frame.
- A sync that arrives exactly when ch=0 (frame boundary) is legal and raises no error.
- Completion and sync cannot coincide, because sync forces the word to channel 0.
- Outputs change only on a frame completion or on reset. A partial frame is never visible on a..h.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Word accepted at edge N: the new ch is visible on sel* immediately after edge N.
- Eighth word (ch=7) accepted at edge N:
  - a..h and frame_done=1 are valid after edge N.
  - frame_done falls after edge N+1 unless another frame also completes at N+1, which is impossible, since the minimum frame period is 8 cycles.
- frame_err is high for exactly one cycle following the offending sync edge.
- Throughput: one word per cycle, so back-to-back frames give frame_done every 8 cycles.
- Gaps (valid=0) may occur anywhere within a frame and do not abort it.
- enable low for any number of cycles pauses mid-frame. The frame resumes at the same ch when enable returns.

## Test plan
- Reset then a full frame: rst_n=0 for 2 cycles. Then sync=1 with in=0 and valid=1, followed by in=1..7 on 7 consecutive cycles. Required response:
  - sel* steps 1,2,..,7,0.
  - After the 8th edge, a..h = 0,1,2,3,4,5,6,7 and frame_done pulses for one cycle.
  - frame_err stays 0.
- Atomic update: load frame A = 0..7. Then send frame B = 8..F (hex) with valid gaps of 2 cycles between words. Required response:
  - a..h hold 0..7 until B's 8th word.
  - Then a..h switch to 8..F in one edge.
- Sync abort: send 4 words (ch=4), then sync with in=9 and valid=1. Required response:
  - frame_err=1 for one cycle, ch=1, and a..h unchanged.
  - Completing that frame yields a=9.
- Enable freeze: mid-frame at ch=3, drop enable for 5 cycles while toggling valid, sync and in. Required response:
  - ch stays 3, no writes occur and the pulses stay 0.
  - After enable returns, 5 more words complete the frame correctly.
- Reset mid-frame: at ch=5, assert rst_n=0 for 1 cycle. Required response:
  - ch=0, a..h=0 and both pulses 0.
  - A following full frame of F,E,..,8 gives a..h = F..8.
- Back-to-back frames: 3 frames of continuous valid, the first started by sync. Required response:
  - frame_done at cycles 8, 16 and 24.
  - Each frame's values appear exactly once on a..h.

Source files
------------

// File: rtl/tdm_demux_1x8_4bit.sv
// Receive-side TDM demultiplexer: collects eight 4-bit channel words into a
// shadow bank and publishes them atomically on a..h when a frame completes.
module tdm_demux_1x8_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  input  logic       valid,
  input  logic       sync,
  input  logic       enable,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic [3:0] e,
  output logic [3:0] f,
  output logic [3:0] g,
  output logic [3:0] h,
  output logic       frame_done,
  output logic       frame_err
);

  logic [2:0] ch;
  logic [3:0] sh [0:7];

  assign {sel2, sel1, sel0} = ch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch         <= '0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      d          <= '0;
      e          <= '0;
      f          <= '0;
      g          <= '0;
      h          <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        sh[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (enable) begin
        if (sync) begin
          // sync always realigns to channel 0; a non-zero ch means a cut frame
          frame_err <= (ch != 3'd0);
          if (valid) begin
            sh[0] <= in;
            ch    <= 3'd1;
          end else begin
            ch <= 3'd0;
          end
        end else if (valid) begin
          sh[ch] <= in;
          ch     <= ch + 3'd1;
          if (ch == 3'd7) begin
            // final word goes straight to h; sh[7] still holds the old value
            a          <= sh[0];
            b          <= sh[1];
            c          <= sh[2];
            d          <= sh[3];
            e          <= sh[4];
            f          <= sh[5];
            g          <= sh[6];
            h          <= in;
            frame_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1x8_4bit.sv
// Directed self-checking bench for tdm_demux_1x8_4bit.
`timescale 1ns/1ps
module tb_tdm_demux_1x8_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic       valid;
  logic       sync;
  logic       enable;
  logic       sel0, sel1, sel2;
  logic [3:0] a, b, c, d, e, f, g, h;
  logic       frame_done;
  logic       frame_err;

  logic [2:0]  sel;
  logic [31:0] outs;

  int checks;
  int errors;

  assign sel  = {sel2, sel1, sel0};
  assign outs = {a, b, c, d, e, f, g, h};

  tdm_demux_1x8_4bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .valid      (valid),
    .sync       (sync),
    .enable     (enable),
    .sel0       (sel0),
    .sel1       (sel1),
    .sel2       (sel2),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .h          (h),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [3:0] data, input logic s, input logic v);
    rst_n  = 1'b1;
    enable = 1'b1;
    in     = data;
    sync   = s;
    valid  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    send(4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    in     = 4'hA;
    valid  = 1'b1;
    sync   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    valid = 1'b0;
    sync  = 1'b0;
    checks++;
    if (sel !== 3'd0) begin
      errors++; $display("FAIL reset_sel: got %0d expected 0", sel);
    end
    checks++;
    if (outs !== 32'h0) begin
      errors++; $display("FAIL reset_outs: got %h expected 00000000", outs);
    end
    checks++;
    if ({frame_done, frame_err} !== 2'b00) begin
      errors++; $display("FAIL reset_pulses: got %b expected 00", {frame_done, frame_err});
    end
  endtask

  task automatic test_full_frame();
    logic [2:0] exp_sel;
    send(4'h0, 1'b1, 1'b1);
    checks++;
    if (sel !== 3'd1) begin
      errors++; $display("FAIL full_sel0: got %0d expected 1", sel);
    end
    for (int i = 1; i < 8; i++) begin
      send(4'(i), 1'b0, 1'b1);
      exp_sel = 3'((i + 1) % 8);
      checks++;
      if (sel !== exp_sel) begin
        errors++; $display("FAIL full_sel: got %0d expected %0d", sel, exp_sel);
      end
      checks++;
      if (frame_done !== (i == 7)) begin
        errors++; $display("FAIL full_done: beat %0d got %b expected %b", i, frame_done, (i == 7));
      end
      checks++;
      if (frame_err !== 1'b0) begin
        errors++; $display("FAIL full_err: beat %0d got %b expected 0", i, frame_err);
      end
    end
    checks++;
    if (outs !== 32'h01234567) begin
      errors++; $display("FAIL full_outs: got %h expected 01234567", outs);
    end
    idle();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL full_done_fall: got %b expected 0", frame_done);
    end
  endtask

  task automatic test_atomic_update();
    for (int i = 0; i < 8; i++) begin
      send(4'(8 + i), (i == 0), 1'b1);
      if (i < 7) begin
        checks++;
        if (outs !== 32'h01234567 || frame_done !== 1'b0) begin
          errors++; $display("FAIL atomic_hold: beat %0d got %h/%b expected 01234567/0", i, outs, frame_done);
        end
        repeat (2) begin
          idle();
          checks++;
          if (outs !== 32'h01234567) begin
            errors++; $display("FAIL atomic_gap: got %h expected 01234567", outs);
          end
        end
      end
    end
    checks++;
    if (outs !== 32'h89ABCDEF || frame_done !== 1'b1) begin
      errors++; $display("FAIL atomic_switch: got %h/%b expected 89abcdef/1", outs, frame_done);
    end
  endtask

  task automatic test_sync_abort();
    for (int i = 0; i < 4; i++) send(4'(i + 1), (i == 0), 1'b1);
    checks++;
    if (sel !== 3'd4 || frame_err !== 1'b0) begin
      errors++; $display("FAIL abort_pre: got sel %0d err %b expected 4/0", sel, frame_err);
    end
    send(4'h9, 1'b1, 1'b1);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL abort_err: got %b expected 1", frame_err);
    end
    checks++;
    if (sel !== 3'd1) begin
      errors++; $display("FAIL abort_sel: got %0d expected 1", sel);
    end
    checks++;
    if (outs !== 32'h89ABCDEF) begin
      errors++; $display("FAIL abort_outs: got %h expected 89abcdef", outs);
    end
    idle();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL abort_err_fall: got %b expected 0", frame_err);
    end
    for (int i = 1; i < 8; i++) send(4'(i), 1'b0, 1'b1);
    checks++;
    if (outs !== 32'h91234567 || frame_done !== 1'b1) begin
      errors++; $display("FAIL abort_complete: got %h/%b expected 91234567/1", outs, frame_done);
    end
  endtask

  task automatic test_enable_freeze();
    logic [2:0] t;
    send(4'h7, 1'b1, 1'b1);
    send(4'h6, 1'b0, 1'b1);
    send(4'h5, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      t      = 3'(i);
      enable = 1'b0;
      in     = 4'(15 - i);
      valid  = t[0] | (i == 3);
      sync   = t[1];
      @(posedge clk);
      #1;
      checks++;
      if (sel !== 3'd3 || frame_done !== 1'b0 || frame_err !== 1'b0) begin
        errors++; $display("FAIL freeze_hold: cycle %0d got sel %0d done %b err %b expected 3/0/0", i, sel, frame_done, frame_err);
      end
    end
    for (int i = 0; i < 5; i++) begin
      send(4'(4 - i), 1'b0, 1'b1);
      checks++;
      if (sel !== 3'((4 + i) % 8)) begin
        errors++; $display("FAIL freeze_resume_sel: got %0d expected %0d", sel, (4 + i) % 8);
      end
    end
    checks++;
    if (outs !== 32'h76543210 || frame_done !== 1'b1) begin
      errors++; $display("FAIL freeze_complete: got %h/%b expected 76543210/1", outs, frame_done);
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 5; i++) send(4'(10 + i), (i == 0), 1'b1);
    checks++;
    if (sel !== 3'd5) begin
      errors++; $display("FAIL midrst_pre: got %0d expected 5", sel);
    end
    rst_n = 1'b0;
    valid = 1'b1;
    sync  = 1'b0;
    in    = 4'hF;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (sel !== 3'd0 || outs !== 32'h0) begin
      errors++; $display("FAIL midrst_state: got sel %0d outs %h expected 0/00000000", sel, outs);
    end
    checks++;
    if ({frame_done, frame_err} !== 2'b00) begin
      errors++; $display("FAIL midrst_pulses: got %b expected 00", {frame_done, frame_err});
    end
    for (int i = 0; i < 8; i++) send(4'(15 - i), 1'b0, 1'b1);
    checks++;
    if (outs !== 32'hFEDCBA98 || frame_done !== 1'b1) begin
      errors++; $display("FAIL midrst_frame: got %h/%b expected fedcba98/1", outs, frame_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] frames [3];
    logic [3:0]  w;
    logic [31:0] exp_outs;
    int          k, j, done_count;
    for (int n = 0; n < 24; n++) begin
      k = n / 8;
      j = n % 8;
      w = (k == 0) ? 4'(j) : (k == 1) ? 4'(8 + j) : 4'(15 - j);
      frames[k][31 - 4*j -: 4] = w;
    end
    done_count = 0;
    for (int n = 0; n < 24; n++) begin
      k = n / 8;
      j = n % 8;
      w = (k == 0) ? 4'(j) : (k == 1) ? 4'(8 + j) : 4'(15 - j);
      send(w, (n == 0), 1'b1);
      if (frame_done === 1'b1) done_count++;
      exp_outs = (j == 7) ? frames[k] : (k == 0) ? 32'hFEDCBA98 : frames[k - 1];
      checks++;
      if (frame_done !== (j == 7)) begin
        errors++; $display("FAIL b2b_done: cycle %0d got %b expected %b", n + 1, frame_done, (j == 7));
      end
      checks++;
      if (outs !== exp_outs) begin
        errors++; $display("FAIL b2b_outs: cycle %0d got %h expected %h", n + 1, outs, exp_outs);
      end
      checks++;
      if (frame_err !== 1'b0) begin
        errors++; $display("FAIL b2b_err: cycle %0d got %b expected 0", n + 1, frame_err);
      end
    end
    checks++;
    if (done_count != 3) begin
      errors++; $display("FAIL b2b_done_count: got %0d expected 3", done_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    in     = 4'h0;
    valid  = 1'b0;
    sync   = 1'b0;
    test_reset();
    test_full_frame();
    test_atomic_update();
    test_sync_abort();
    test_enable_freeze();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
